// File: rtl/hs_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : hs_rr_arbiter
// Brief    : Round-robin packet arbiter that merges NUM_SRC valid/ready
//            streams onto one output through a two-entry main/skid buffer.
// Revision : 1.0
// ============================================================================
module hs_rr_arbiter #(
    parameter int WIDTH   = 8,
    parameter int NUM_SRC = 4,
    parameter int ID_W    = $clog2(NUM_SRC)
) (
    input  logic                     clk,
    input  logic                     s_rst,
    input  logic [NUM_SRC-1:0]       src_valid,
    input  logic [NUM_SRC*WIDTH-1:0] src_data,
    input  logic [NUM_SRC-1:0]       src_last,
    output logic [NUM_SRC-1:0]       src_ready,
    output logic                     dst_valid,
    output logic [WIDTH-1:0]         dst_data,
    output logic                     dst_last,
    output logic [ID_W-1:0]          dst_id,
    input  logic                     dst_ready
);

    localparam logic [0:0]      IDLE       = 1'b0;
    localparam logic [0:0]      LOCKED     = 1'b1;
    localparam logic [ID_W-1:0] C_LAST_SRC = ID_W'(NUM_SRC - 1);

    logic [0:0]       state_q,      state_d;
    logic [ID_W-1:0]  grant_q,      grant_d;
    logic [ID_W-1:0]  last_ptr_q,   last_ptr_d;

    logic             main_valid_q, main_valid_d;
    logic [WIDTH-1:0] main_data_q,  main_data_d;
    logic             main_last_q,  main_last_d;
    logic [ID_W-1:0]  main_id_q,    main_id_d;

    logic             skid_valid_q, skid_valid_d;
    logic [WIDTH-1:0] skid_data_q,  skid_data_d;
    logic             skid_last_q,  skid_last_d;
    logic [ID_W-1:0]  skid_id_q,    skid_id_d;

    logic             w_any_valid;
    logic [ID_W-1:0]  w_next_grant;
    int               w_dist;
    int               w_best_dist;
    logic             w_beat_valid;
    logic [WIDTH-1:0] w_beat_data;
    logic             w_beat_last;
    logic             w_ready_en;
    logic             w_accept;
    logic             w_drain;

    // Pick the valid source closest after last_ptr in circular order.
    always_comb begin
        w_any_valid  = 1'b0;
        w_next_grant = '0;
        w_best_dist  = NUM_SRC;
        w_dist       = 0;
        for (int i = 0; i < NUM_SRC; i++) begin
            w_dist = i - int'(last_ptr_q) - 1;
            if (w_dist < 0) begin
                w_dist = w_dist + NUM_SRC;
            end
            if (src_valid[i] && (w_dist < w_best_dist)) begin
                w_best_dist  = w_dist;
                w_next_grant = ID_W'(i);
                w_any_valid  = 1'b1;
            end
        end
    end

    always_comb begin
        w_beat_valid = 1'b0;
        w_beat_data  = '0;
        w_beat_last  = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (grant_q == ID_W'(i)) begin
                w_beat_valid = src_valid[i];
                w_beat_data  = src_data[i*WIDTH +: WIDTH];
                w_beat_last  = src_last[i];
            end
        end
    end

    // Ready depends only on registered state, never on dst_ready.
    assign w_ready_en = (state_q == LOCKED) && !skid_valid_q;
    assign w_accept   = w_ready_en && w_beat_valid;
    assign w_drain    = main_valid_q && dst_ready;

    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_ready
        assign src_ready[gi] = w_ready_en && (grant_q == ID_W'(gi));
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        last_ptr_d = last_ptr_q;
        case (state_q)
            IDLE: begin
                if (w_any_valid) begin
                    grant_d = w_next_grant;
                    state_d = LOCKED;
                end
            end
            LOCKED: begin
                if (w_accept && w_beat_last) begin
                    state_d    = IDLE;
                    last_ptr_d = grant_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        main_valid_d = main_valid_q;
        main_data_d  = main_data_q;
        main_last_d  = main_last_q;
        main_id_d    = main_id_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        skid_last_d  = skid_last_q;
        skid_id_d    = skid_id_q;
        if (w_drain) begin
            // A full skid blocks acceptance, so skid refill and accept never coincide.
            if (skid_valid_q) begin
                main_valid_d = 1'b1;
                main_data_d  = skid_data_q;
                main_last_d  = skid_last_q;
                main_id_d    = skid_id_q;
                skid_valid_d = 1'b0;
            end else if (w_accept) begin
                main_valid_d = 1'b1;
                main_data_d  = w_beat_data;
                main_last_d  = w_beat_last;
                main_id_d    = grant_q;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (w_accept) begin
            if (!main_valid_q) begin
                main_valid_d = 1'b1;
                main_data_d  = w_beat_data;
                main_last_d  = w_beat_last;
                main_id_d    = grant_q;
            end else begin
                skid_valid_d = 1'b1;
                skid_data_d  = w_beat_data;
                skid_last_d  = w_beat_last;
                skid_id_d    = grant_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (s_rst) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_ptr_q   <= C_LAST_SRC;
            main_valid_q <= 1'b0;
            main_data_q  <= '0;
            main_last_q  <= 1'b0;
            main_id_q    <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            skid_last_q  <= 1'b0;
            skid_id_q    <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_ptr_q   <= last_ptr_d;
            main_valid_q <= main_valid_d;
            main_data_q  <= main_data_d;
            main_last_q  <= main_last_d;
            main_id_q    <= main_id_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            skid_last_q  <= skid_last_d;
            skid_id_q    <= skid_id_d;
        end
    end

    assign dst_valid = main_valid_q;
    assign dst_data  = main_data_q;
    assign dst_last  = main_last_q;
    assign dst_id    = main_id_q;

endmodule
`default_nettype wire

// File: tb/tb_hs_rr_arbiter.sv
`default_nettype none
// Bench for hs_rr_arbiter: queue-based reference model checked every cycle,
// plus literal expectations for the directed scenarios.
module tb_hs_rr_arbiter;

    localparam int WIDTH   = 8;
    localparam int NUM_SRC = 4;
    localparam int ID_W    = 2;

    logic                     clk = 1'b0;
    logic                     s_rst;
    logic [NUM_SRC-1:0]       src_valid;
    logic [NUM_SRC*WIDTH-1:0] src_data;
    logic [NUM_SRC-1:0]       src_last;
    logic [NUM_SRC-1:0]       src_ready;
    logic                     dst_valid;
    logic [WIDTH-1:0]         dst_data;
    logic                     dst_last;
    logic [ID_W-1:0]          dst_id;
    logic                     dst_ready;

    always #5 clk = ~clk;

    hs_rr_arbiter #(.WIDTH(WIDTH), .NUM_SRC(NUM_SRC), .ID_W(ID_W)) dut (
        .clk(clk), .s_rst(s_rst),
        .src_valid(src_valid), .src_data(src_data), .src_last(src_last),
        .src_ready(src_ready),
        .dst_valid(dst_valid), .dst_data(dst_data), .dst_last(dst_last),
        .dst_id(dst_id), .dst_ready(dst_ready)
    );

    typedef struct packed { logic [7:0] d; logic l; } beat_t;
    typedef struct packed { logic [1:0] id; logic l; logic [7:0] d; } obeat_t;

    beat_t  srcq [NUM_SRC][$];
    obeat_t mq[$];
    bit     m_locked;
    logic [1:0] m_grant, m_last_ptr;
    int     max_fill;
    obeat_t out_log[$];
    int     out_cyc[$];
    int     cyc;
    int     n_vec = 0;
    int     n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic obeat_t ob(input int id, input bit l, input int d);
        return {id[1:0], l, d[7:0]};
    endfunction

    function automatic beat_t bt(input int d, input bit l);
        return {d[7:0], l};
    endfunction

    task automatic drive();
        for (int i = 0; i < NUM_SRC; i++) begin
            if (srcq[i].size() > 0) begin
                src_valid[i]               = 1'b1;
                src_data[i*WIDTH +: WIDTH] = srcq[i][0].d;
                src_last[i]                = srcq[i][0].l;
            end else begin
                src_valid[i]               = 1'b0;
                src_data[i*WIDTH +: WIDTH] = '0;
                src_last[i]                = 1'b0;
            end
        end
    endtask

    // One clock: model predicts, DUT steps, outputs compared #1 after the edge.
    task automatic tick();
        logic [NUM_SRC-1:0] rdy_seen;
        logic [3:0] exp_rdy;
        bit nl, acc, drn;
        logic [1:0] ng, nlp;
        obeat_t nb;
        int idx;
        drive();
        if (!s_rst && dst_valid && dst_ready) begin
            out_log.push_back({dst_id, dst_last, dst_data});
            out_cyc.push_back(cyc);
        end
        rdy_seen = src_ready;
        nl = m_locked; ng = m_grant; nlp = m_last_ptr; acc = 0; drn = 0; nb = '0;
        if (!s_rst) begin
            acc = m_locked && (mq.size() < 2) && src_valid[m_grant];
            nb  = {m_grant, src_last[m_grant], src_data[m_grant*WIDTH +: WIDTH]};
            if (!m_locked) begin
                for (int k = 1; k <= NUM_SRC; k++) begin
                    idx = (int'(m_last_ptr) + k) % NUM_SRC;
                    if (!nl && src_valid[idx]) begin
                        nl = 1;
                        ng = idx[1:0];
                    end
                end
            end else if (acc && src_last[m_grant]) begin
                nl  = 0;
                nlp = m_grant;
            end
            drn = (mq.size() > 0) && dst_ready;
        end
        @(posedge clk);
        cyc++;
        if (s_rst) begin
            m_locked = 0; m_grant = 2'd0; m_last_ptr = 2'd3;
            mq.delete();
        end else begin
            for (int i = 0; i < NUM_SRC; i++)
                if (rdy_seen[i] && src_valid[i]) void'(srcq[i].pop_front());
            if (drn) void'(mq.pop_front());
            if (acc) mq.push_back(nb);
            m_locked = nl; m_grant = ng; m_last_ptr = nlp;
        end
        if (mq.size() > max_fill) max_fill = mq.size();
        #1;
        exp_rdy = (m_locked && mq.size() < 2) ? (4'b0001 << m_grant) : 4'b0000;
        check("src_ready", src_ready, exp_rdy);
        check("dst_valid", dst_valid, mq.size() > 0);
        if (mq.size() > 0) begin
            check("dst_data", dst_data, mq[0].d);
            check("dst_last", dst_last, mq[0].l);
            check("dst_id",   dst_id,   mq[0].id);
        end
    endtask

    task automatic drain_all(input int max_cyc);
        int n;
        n = 0;
        while ((srcq[0].size() + srcq[1].size() + srcq[2].size() + srcq[3].size() > 0 ||
                mq.size() > 0 || m_locked) && n < max_cyc) begin
            tick();
            n++;
        end
        check("drain_done", n < max_cyc, 1);
    endtask

    task automatic check_log(input string tag, input obeat_t exp[$], input int spacing);
        check({tag, "_count"}, out_log.size(), exp.size());
        for (int k = 0; k < exp.size() && k < out_log.size(); k++) begin
            check({tag, "_beat"}, out_log[k], exp[k]);
            if (spacing > 0) check({tag, "_gap"}, out_cyc[k] - out_cyc[0], k * spacing);
        end
    endtask

    task automatic reset_dut();
        s_rst     = 1'b1;
        dst_ready = 1'b1;
        for (int i = 0; i < NUM_SRC; i++) srcq[i].delete();
        tick();
        tick();
        s_rst = 1'b0;
        out_log.delete();
        out_cyc.delete();
        max_fill = 0;
    endtask

    initial begin
        obeat_t e[$];
        s_rst = 1'b1; dst_ready = 1'b1;
        src_valid = '0; src_data = '0; src_last = '0;
        m_locked = 0; m_grant = 2'd0; m_last_ptr = 2'd3; cyc = 0; max_fill = 0;

        reset_dut();
        check("rst_src_ready", src_ready, 4'b0000);
        check("rst_dst_valid", dst_valid, 0);
        check("rst_dst_data",  dst_data, 8'h00);
        check("rst_dst_last",  dst_last, 0);
        check("rst_dst_id",    dst_id, 2'd0);

        // Single source, 4-beat packet, no backpressure
        for (int k = 0; k < 4; k++) srcq[0].push_back(bt(8'h11 + k, k == 3));
        tick();
        check("t1_ready_rise", src_ready, 4'b0001);
        drain_all(30);
        e.delete();
        for (int k = 0; k < 4; k++) e.push_back(ob(0, k == 3, 8'h11 + k));
        check_log("t1", e, 1);

        // All sources valid after reset, single-beat packets
        reset_dut();
        for (int i = 0; i < NUM_SRC; i++) srcq[i].push_back(bt(8'hA0 + i, 1'b1));
        srcq[0].push_back(bt(8'hB0, 1'b1));
        drain_all(40);
        e.delete();
        for (int i = 0; i < NUM_SRC; i++) e.push_back(ob(i, 1, 8'hA0 + i));
        e.push_back(ob(0, 1, 8'hB0));
        check_log("t2", e, 2);

        // Source 2 holds grant; source 1 waits, no source 3
        reset_dut();
        for (int k = 0; k < 3; k++) srcq[2].push_back(bt(8'h31 + k, k == 2));
        tick();
        check("t3a_grant2", src_ready, 4'b0100);
        srcq[1].push_back(bt(8'hC1, 1'b1));
        drain_all(30);
        e.delete();
        for (int k = 0; k < 3; k++) e.push_back(ob(2, k == 2, 8'h31 + k));
        e.push_back(ob(1, 1, 8'hC1));
        check_log("t3a", e, 0);

        // Same, with source 3 also waiting: 3 goes before 1
        reset_dut();
        for (int k = 0; k < 3; k++) srcq[2].push_back(bt(8'h41 + k, k == 2));
        tick();
        srcq[1].push_back(bt(8'hC1, 1'b1));
        srcq[3].push_back(bt(8'hE3, 1'b1));
        drain_all(30);
        e.delete();
        for (int k = 0; k < 3; k++) e.push_back(ob(2, k == 2, 8'h41 + k));
        e.push_back(ob(3, 1, 8'hE3));
        e.push_back(ob(1, 1, 8'hC1));
        check_log("t3b", e, 0);

        // Backpressure on a 6-beat packet, dst_ready low in cycles 2..5
        reset_dut();
        for (int k = 0; k < 6; k++) srcq[0].push_back(bt(8'h61 + k, k == 5));
        for (int k = 0; k < 8; k++) begin
            dst_ready = !(k >= 2 && k <= 5);
            tick();
            if (k == 2) check("t4_skid_full_ready", src_ready, 4'b0000);
            if (k == 5) check("t4_stall_ready",     src_ready, 4'b0000);
            if (k == 6) check("t4_release_ready",   src_ready, 4'b0001);
        end
        dst_ready = 1'b1;
        drain_all(30);
        check("t4_max_buffered", max_fill, 2);
        e.delete();
        for (int k = 0; k < 6; k++) e.push_back(ob(0, k == 5, 8'h61 + k));
        check_log("t4", e, 0);

        // Reset during beat 2 of a 4-beat packet
        reset_dut();
        for (int k = 0; k < 4; k++) srcq[0].push_back(bt(8'h51 + k, k == 3));
        tick();
        tick();
        s_rst = 1'b1;
        tick();
        check("t5_rst_dst_valid", dst_valid, 0);
        check("t5_rst_src_ready", src_ready, 4'b0000);
        s_rst = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) srcq[i].delete();
        out_log.delete();
        out_cyc.delete();
        srcq[3].push_back(bt(8'hD3, 1'b1));
        srcq[0].push_back(bt(8'hD0, 1'b1));
        tick();
        check("t5_grant0", src_ready, 4'b0001);
        drain_all(30);
        e.delete();
        e.push_back(ob(0, 1, 8'hD0));
        e.push_back(ob(3, 1, 8'hD3));
        check_log("t5", e, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/hs_rr_arbiter.md
# hs_rr_arbiter

Round-robin packet arbiter that shares one valid/ready output stream among NUM_SRC requesting source streams. Grant is held for a whole packet, from the first beat through the beat flagged `src_last`. The output side is a two-entry registered slice (main + skid), so no `src_ready` depends combinationally on `dst_ready`. The block sits between several producers and a single downstream handshake consumer.

## Interface
- WIDTH, 8, data width per beat
- NUM_SRC, 4, number of requesters, legal 2..8
- ID_W, ceil(log2(NUM_SRC)) (2 at default), width of the source-id field
- clk  input  1  clock; all logic on rising edge
- s_rst  input  1  reset, synchronous, active-high
- src_valid  input  NUM_SRC  per-source beat valid
- src_data  input  NUM_SRC*WIDTH  source i occupies bits [i*WIDTH +: WIDTH]
- src_last  input  NUM_SRC  per-source end-of-packet flag, qualified by valid
- src_ready  output  NUM_SRC  per-source accept; at most one bit high
- dst_valid  output  1  output beat valid
- dst_data  output  WIDTH  output beat data
- dst_last  output  1  end-of-packet for output beat
- dst_id  output  ID_W  index of the source that produced the output beat
- dst_ready  input  1  downstream accept

## Operation
- FSM states: IDLE, LOCKED. Register `grant` (ID_W bits); register `last_ptr` (ID_W bits).
- IDLE: all `src_ready` = 0.
  - If any `src_valid` is 1, select the first valid source searching `last_ptr+1, last_ptr+2, …` modulo NUM_SRC.
  - Load that index into `grant` and go to LOCKED.
  - If no source is valid, stay in IDLE.
- LOCKED: `src_ready[grant]` = !skid_valid; all other bits are 0.
  - A beat transfers when `src_valid[grant] & src_ready[grant]`.
  - A transfer with `src_last[grant]` = 1: next state IDLE, `last_ptr <= grant`.
  - A source that drops valid mid-packet keeps the grant; there is no timeout.
- Single-beat packet: `src_last` = 1 on the first beat gives IDLE→LOCKED→IDLE.
- Output buffer: main {data, last, id, valid} and skid {data, last, id, valid}.
  - `dst_valid` = main_valid; `dst_data`/`dst_last`/`dst_id` are taken from main.
  - Accepted beat, main empty or (main draining by `dst_ready` and skid empty): beat goes to main.
  - Accepted beat, main full and not draining: beat goes to skid.
  - Main draining with skid valid: main <= skid, skid cleared.
  - Main draining, no skid and no accepted beat: main_valid <= 0.
- Ordering is preserved exactly; no beat is dropped or duplicated.
- Non-granted sources must not change `dst_*`.
- Reset mid-packet: FSM to IDLE, `grant` = 0, `last_ptr` = NUM_SRC-1, both buffer entries invalidated and buffered beats discarded.

## Timing
- Reset values: `src_ready` = 0, `dst_valid` = 0, `dst_data` = 0, `dst_last` = 0, `dst_id` = 0.
- After reset, source 0 has top priority, because `last_ptr` = NUM_SRC-1.
- Arbitration cost: one cycle. A request seen in IDLE at cycle t gives `src_ready` at t+1.
- Between packets there is one IDLE bubble cycle: `src_ready` = 0 in the cycle after a last-beat transfer.
- Data latency: a beat accepted at edge t appears on `dst_*` after edge t, when main is empty or draining.
- Sustained throughput with `dst_ready` = 1: one beat per cycle within a packet.
- Backpressure, `dst_ready` 1→0:
  - One more beat can be accepted into skid.
  - `src_ready[grant]` falls the cycle after skid fills.
  - It rises the cycle after main drains, moving skid into main.
- `dst_ready` = 1 and an accept in the same cycle with skid empty: main is replaced by the new beat, with no bubble.

## Test plan
- Single source, one packet of 4 beats (0x11..0x14) with `dst_ready` = 1:
  - `src_ready[0]` rises 1 cycle after `src_valid`.
  - `dst_data` = 0x11,0x12,0x13,0x14 on consecutive cycles, `dst_last` on 0x14, `dst_id` = 0.
- All 4 sources valid after reset, 1-beat packets each:
  - Grant order 0,1,2,3,0, with one bubble cycle between grants.
  - `dst_id` follows the same sequence.
- Source 2 mid-packet (3 beats) while source 1 requests:
  - Source 1 gets `src_ready` = 0 until source 2's last beat transfers, then the grant goes to source 3 if valid, else source 1.
- Backpressure: 6-beat packet, `dst_ready` held 0 for cycles 2–5:
  - Exactly 2 beats are buffered; `src_ready` = 0 while skid is full.
  - After release, all 6 beats arrive in order, with none lost or repeated.
- `s_rst` asserted during beat 2 of a 4-beat packet:
  - The next cycle shows `dst_valid` = 0 and all `src_ready` = 0.
  - A new request from source 3 with source 0 also valid is granted to source 0.
